// File: rtl/accumulation_buffer_rmw.sv
// Ping-pong accumulation buffer: lane-wise read-modify-write into the active bank,
// with write-to-read forwarding, and a drain port on the other bank that can clear words as they are read.
module accumulation_buffer_rmw #(
  parameter int LANES           = 4,
  parameter int LANE_WIDTH      = 16,
  parameter int BANK_ADDR_WIDTH = 7,
  parameter int BANK_DEPTH      = 128,
  parameter int SATURATE        = 1,
  parameter int CLEAR_ON_DRAIN  = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            switch_banks,
  input  logic                            acc_valid,
  input  logic                            acc_first,
  input  logic [BANK_ADDR_WIDTH-1:0]      acc_adr,
  input  logic [LANES*LANE_WIDTH-1:0]     acc_data,
  output logic                            drain_ready,
  input  logic                            drain_ren,
  input  logic [BANK_ADDR_WIDTH-1:0]      drain_adr,
  output logic                            drain_valid,
  output logic [LANES*LANE_WIDTH-1:0]     drain_data,
  output logic                            active_bank
);

  localparam int DATA_WIDTH = LANES * LANE_WIDTH;
  localparam logic [BANK_ADDR_WIDTH:0] DEPTH_L = BANK_DEPTH[BANK_ADDR_WIDTH:0];

  function automatic logic [LANE_WIDTH-1:0] lane_add(input logic signed [LANE_WIDTH-1:0] a,
                                                     input logic signed [LANE_WIDTH-1:0] b);
    logic signed [LANE_WIDTH:0] s;
    s = {a[LANE_WIDTH-1], a} + {b[LANE_WIDTH-1], b};
    if ((SATURATE != 0) && (s[LANE_WIDTH] != s[LANE_WIDTH-1]))
      lane_add = s[LANE_WIDTH] ? {1'b1, {(LANE_WIDTH-1){1'b0}}} : {1'b0, {(LANE_WIDTH-1){1'b1}}};
    else
      lane_add = s[LANE_WIDTH-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] word_add(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
    for (int i = 0; i < LANES; i++)
      word_add[i*LANE_WIDTH +: LANE_WIDTH] = lane_add(a[i*LANE_WIDTH +: LANE_WIDTH],
                                                      b[i*LANE_WIDTH +: LANE_WIDTH]);
  endfunction

  logic                       vld_p1, first_p1, bank_p1;
  logic [BANK_ADDR_WIDTH-1:0] adr_p1;
  logic [DATA_WIDTH-1:0]      data_p1;
  logic                       fwd_vld_p2, fwd_bank_p2;
  logic [BANK_ADDR_WIDTH-1:0] fwd_adr_p2;
  logic [DATA_WIDTH-1:0]      fwd_data_p2;
  logic                       drain_bank_p1;
  logic                       acc_we, clr_we, drain_accept, fwd_hit;
  logic [DATA_WIDTH-1:0]      acc_rdata_p1, old_p1, new_p1, drain_rdata_p1;

  // A write still owed to the bank that just became the drain bank owns its write port for one cycle.
  assign drain_ready  = ~(vld_p1 & (bank_p1 != active_bank));
  assign drain_accept = drain_ren & drain_ready;
  assign acc_we       = vld_p1 & ~rst;
  assign clr_we       = (CLEAR_ON_DRAIN != 0) & drain_accept & ~rst;

  for (genvar g = 0; g < 2; g++) begin : g_ram
    localparam bit BANK = (g == 1);
    logic                       we;
    logic [BANK_ADDR_WIDTH-1:0] wadr, radr;
    logic [DATA_WIDTH-1:0]      wdata, rdata;
    logic [DATA_WIDTH-1:0]      mem [BANK_DEPTH];

    always_comb begin
      radr  = (active_bank == BANK) ? acc_adr : drain_adr;
      we    = 1'b0;
      wadr  = drain_adr;
      wdata = '0;
      if (acc_we && (bank_p1 == BANK)) begin
        we    = 1'b1;
        wadr  = adr_p1;
        wdata = new_p1;
      end else if (clr_we && (active_bank != BANK)) begin
        we    = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (we && ({1'b0, wadr} < DEPTH_L))
        mem[wadr] <= wdata;
      rdata <= mem[radr];
    end
  end

  // ---- stage p1: merge SRAM read with the previous cycle's write, then add ----
  always_comb begin
    acc_rdata_p1   = bank_p1 ? g_ram[1].rdata : g_ram[0].rdata;
    drain_rdata_p1 = drain_bank_p1 ? g_ram[1].rdata : g_ram[0].rdata;
    fwd_hit        = fwd_vld_p2 && (fwd_bank_p2 == bank_p1) && (fwd_adr_p2 == adr_p1);
    old_p1         = fwd_hit ? fwd_data_p2 : acc_rdata_p1;
    new_p1         = first_p1 ? data_p1 : word_add(old_p1, data_p1);
  end

  assign drain_data = drain_valid ? drain_rdata_p1 : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_bank <= 1'b0;
      vld_p1      <= 1'b0;
      fwd_vld_p2  <= 1'b0;
      drain_valid <= 1'b0;
    end else begin
      if (switch_banks)
        active_bank <= ~active_bank;
      vld_p1      <= acc_valid;
      fwd_vld_p2  <= vld_p1;
      drain_valid <= drain_accept;
    end
  end

  // ---- stage p0 -> p1 request capture, p1 -> p2 forward capture ----
  always_ff @(posedge clk) begin
    first_p1      <= acc_first;
    bank_p1       <= active_bank;
    adr_p1        <= acc_adr;
    data_p1       <= acc_data;
    drain_bank_p1 <= ~active_bank;
    fwd_bank_p2   <= bank_p1;
    fwd_adr_p2    <= adr_p1;
    fwd_data_p2   <= new_p1;
  end

endmodule

// File: tb/tb_accumulation_buffer_rmw.sv
// Bench for accumulation_buffer_rmw: saturating and wrapping instances share stimulus and are
// compared against a word-level bank model, a directed vector table and a reset-abort sequence.
module tb_accumulation_buffer_rmw;
  localparam int AW = 7;
  localparam int DW = 64;
  localparam int DEPTH = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, switch_banks = 1'b0, acc_valid = 1'b0, acc_first = 1'b0, drain_ren = 1'b0;
  logic [AW-1:0] acc_adr = '0, drain_adr = '0;
  logic [DW-1:0] acc_data = '0;
  logic          rdy_s, dv_s, act_s, rdy_w, dv_w, act_w;
  logic [DW-1:0] dd_s, dd_w;

  accumulation_buffer_rmw #(.SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .switch_banks(switch_banks), .acc_valid(acc_valid), .acc_first(acc_first),
    .acc_adr(acc_adr), .acc_data(acc_data), .drain_ready(rdy_s), .drain_ren(drain_ren),
    .drain_adr(drain_adr), .drain_valid(dv_s), .drain_data(dd_s), .active_bank(act_s));

  accumulation_buffer_rmw #(.SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .switch_banks(switch_banks), .acc_valid(acc_valid), .acc_first(acc_first),
    .acc_adr(acc_adr), .acc_data(acc_data), .drain_ready(rdy_w), .drain_ren(drain_ren),
    .drain_adr(drain_adr), .drain_valid(dv_w), .drain_data(dd_w), .active_bank(act_w));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: two banks of words, requests applied in program order.
  logic [DW-1:0] ms [2][DEPTH];
  logic [DW-1:0] mw [2][DEPTH];
  bit            known [2][DEPTH];
  bit            m_active = 1'b0, m_ready = 1'b1;
  bit            pend_v = 1'b0, pend_b, pend_f;
  logic [AW-1:0] pend_a;
  logic [DW-1:0] pend_d;
  bit            e_dv = 1'b0, e_known = 1'b0;
  logic [DW-1:0] e_s, e_w;

  function automatic logic [DW-1:0] m_add(input logic [DW-1:0] o, input logic [DW-1:0] d, input bit sat);
    logic [DW-1:0] r;
    int a, b, s;
    for (int i = 0; i < 4; i++) begin
      a = $signed(o[i*16 +: 16]);
      b = $signed(d[i*16 +: 16]);
      s = a + b;
      if (sat) begin
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
      end
      r[i*16 +: 16] = s[15:0];
    end
    return r;
  endfunction

  task automatic model_update();
    bit db;
    if (rst) begin
      pend_v = 1'b0;
      m_active = 1'b0;
      m_ready = 1'b1;
      e_dv = 1'b0;
    end else begin
      if (pend_v) begin
        if (pend_f) begin
          ms[pend_b][pend_a] = pend_d;
          mw[pend_b][pend_a] = pend_d;
          known[pend_b][pend_a] = 1'b1;
        end else begin
          ms[pend_b][pend_a] = m_add(ms[pend_b][pend_a], pend_d, 1'b1);
          mw[pend_b][pend_a] = m_add(mw[pend_b][pend_a], pend_d, 1'b0);
        end
      end
      e_dv = drain_ren && m_ready;
      if (e_dv) begin
        db = ~m_active;
        e_known = known[db][drain_adr];
        e_s = ms[db][drain_adr];
        e_w = mw[db][drain_adr];
        ms[db][drain_adr] = '0;
        mw[db][drain_adr] = '0;
        known[db][drain_adr] = 1'b1;
      end
      pend_v = acc_valid;
      pend_b = m_active;
      pend_f = acc_first;
      pend_a = acc_adr;
      pend_d = acc_data;
      m_ready = !(acc_valid && switch_banks);
      if (switch_banks) m_active = ~m_active;
    end
  endtask

  task automatic check_outputs();
    chk("active_s", act_s, m_active);
    chk("active_w", act_w, m_active);
    chk("ready_s", rdy_s, m_ready);
    chk("ready_w", rdy_w, m_ready);
    chk("dvalid_s", dv_s, e_dv);
    chk("dvalid_w", dv_w, e_dv);
    if (!e_dv) begin
      chk("ddata_idle_s", dd_s, '0);
      chk("ddata_idle_w", dd_w, '0);
    end else if (e_known) begin
      chk("ddata_s", dd_s, e_s);
      chk("ddata_w", dd_w, e_w);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    check_outputs();
  endtask

  task automatic set_in(input bit r, input bit sw, input bit av, input bit af, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit dr, input logic [AW-1:0] da);
    rst = r; switch_banks = sw; acc_valid = av; acc_first = af;
    acc_adr = a; acc_data = d; drain_ren = dr; drain_adr = da;
  endtask

  typedef struct {
    bit r, sw, av, af;
    logic [AW-1:0] adr;
    logic [DW-1:0] d;
    bit dren;
    logic [AW-1:0] dadr;
    bit e_act, e_rdy, e_dv;
    logic [DW-1:0] e_ds, e_dw;
  } vec_t;

  function automatic vec_t mk(input bit r, input bit sw, input bit av, input bit af, input int adr,
                              input logic [DW-1:0] d, input bit dren, input int dadr,
                              input bit e_act, input bit e_rdy, input bit e_dv,
                              input logic [DW-1:0] e_ds, input logic [DW-1:0] e_dw);
    vec_t v;
    v.r = r; v.sw = sw; v.av = av; v.af = af; v.adr = adr[AW-1:0]; v.d = d;
    v.dren = dren; v.dadr = dadr[AW-1:0];
    v.e_act = e_act; v.e_rdy = e_rdy; v.e_dv = e_dv; v.e_ds = e_ds; v.e_dw = e_dw;
    return v;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    logic [15:0] l;
    for (int i = 0; i < 4; i++) begin
      case ($urandom_range(0, 3))
        0: l = 16'($urandom);
        1: l = 16'h7FF0 + 16'($urandom_range(0, 15));
        2: l = 16'h8000 + 16'($urandom_range(0, 15));
        default: l = 16'($signed($urandom_range(0, 16)) - 8);
      endcase
      w[i*16 +: 16] = l;
    end
    return w;
  endfunction

  localparam logic [DW-1:0] W2  = 64'h0002_0002_0002_0002;
  localparam logic [DW-1:0] W3  = 64'h0003_0003_0003_0003;
  localparam logic [DW-1:0] W4  = 64'h0004_0004_0004_0004;
  localparam logic [DW-1:0] W5  = 64'h0005_0005_0005_0005;
  localparam logic [DW-1:0] W7  = 64'h0007_0007_0007_0007;
  localparam logic [DW-1:0] W12 = 64'h000C_000C_000C_000C;
  localparam logic [DW-1:0] SA  = 64'hFFFB_0064_8000_7D00;
  localparam logic [DW-1:0] SB  = 64'h0007_FED4_FFFF_03E8;
  localparam logic [DW-1:0] RS  = 64'h0002_FF38_8000_7FFF;
  localparam logic [DW-1:0] RW  = 64'h0002_FF38_7FFF_80E8;

  vec_t vecs[$];

  initial begin
    vecs.push_back(mk(1,0,0,0,0,'0,0,0, 0,1,0,'0,'0));
    vecs.push_back(mk(1,0,0,0,0,'0,0,0, 0,1,0,'0,'0));
    vecs.push_back(mk(0,0,1,1,3,W5,0,0, 0,1,0,'0,'0));
    vecs.push_back(mk(0,0,1,0,3,W7,0,0, 0,1,0,'0,'0));
    vecs.push_back(mk(0,0,1,1,5,SA,0,0, 0,1,0,'0,'0));
    vecs.push_back(mk(0,1,1,0,5,SB,0,0, 1,0,0,'0,'0));
    vecs.push_back(mk(0,0,0,0,0,'0,1,5, 1,1,0,'0,'0));
    vecs.push_back(mk(0,0,0,0,0,'0,1,3, 1,1,1,W12,W12));
    vecs.push_back(mk(0,0,0,0,0,'0,1,5, 1,1,1,RS,RW));
    vecs.push_back(mk(0,0,0,0,0,'0,1,3, 1,1,1,'0,'0));
    vecs.push_back(mk(0,0,1,1,9,W3,0,0, 1,1,0,'0,'0));
    vecs.push_back(mk(0,0,1,0,9,W2,0,0, 1,1,0,'0,'0));
    vecs.push_back(mk(0,1,0,0,0,'0,0,0, 0,1,0,'0,'0));
    vecs.push_back(mk(0,0,0,0,0,'0,1,9, 0,1,1,W5,W5));
    vecs.push_back(mk(0,0,0,0,0,'0,1,9, 0,1,1,'0,'0));
    vecs.push_back(mk(0,1,0,0,0,'0,0,0, 1,1,0,'0,'0));
    vecs.push_back(mk(0,0,1,0,9,W4,0,0, 1,1,0,'0,'0));
    vecs.push_back(mk(0,1,0,0,0,'0,0,0, 0,1,0,'0,'0));
    vecs.push_back(mk(0,0,0,0,0,'0,1,9, 0,1,1,W4,W4));
    vecs.push_back(mk(0,0,0,0,0,'0,0,0, 0,1,0,'0,'0));

    // Establish known SRAM contents by draining (and clearing) every word of both banks.
    set_in(1,0,0,0,0,'0,0,0); cycle(); cycle();
    for (int a = 0; a < DEPTH; a++) begin set_in(0,0,0,0,0,'0,1,a[AW-1:0]); cycle(); end
    set_in(0,1,0,0,0,'0,0,0); cycle();
    for (int a = 0; a < DEPTH; a++) begin set_in(0,0,0,0,0,'0,1,a[AW-1:0]); cycle(); end
    set_in(0,0,0,0,0,'0,0,0); cycle();

    foreach (vecs[i]) begin
      set_in(vecs[i].r, vecs[i].sw, vecs[i].av, vecs[i].af, vecs[i].adr, vecs[i].d,
             vecs[i].dren, vecs[i].dadr);
      cycle();
      chk($sformatf("v%0d_active", i), act_s, vecs[i].e_act);
      chk($sformatf("v%0d_ready", i), rdy_s, vecs[i].e_rdy);
      chk($sformatf("v%0d_dvalid", i), dv_s, vecs[i].e_dv);
      chk($sformatf("v%0d_ddata_sat", i), dd_s, vecs[i].e_ds);
      chk($sformatf("v%0d_ddata_wrap", i), dd_w, vecs[i].e_dw);
    end

    // Reset in the cycle after an accumulate must abort its write.
    set_in(0,0,1,1,20,W7,0,0); cycle();
    set_in(1,0,0,0,0,'0,0,0);  cycle();
    set_in(0,1,0,0,0,'0,0,0);  cycle();
    set_in(0,0,0,0,0,'0,1,20); cycle();
    chk("rst_abort_dvalid", dv_s, 1'b1);
    chk("rst_abort_ddata", dd_s, '0);
    set_in(0,0,0,0,0,'0,0,0);  cycle();

    for (int c = 0; c < 10000; c++) begin
      bit r, sw, av, af, dr;
      logic [AW-1:0] a, da;
      r  = ($urandom_range(0, 499) == 0);
      sw = !r && ($urandom_range(0, 19) == 0);
      av = ($urandom_range(0, 9) < 8);
      af = ($urandom_range(0, 4) == 0);
      dr = !r && ($urandom_range(0, 1) == 1);
      a  = ($urandom_range(0, 15) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      da = ($urandom_range(0, 15) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      set_in(r, sw, av, af, a, rand_word(), dr, da);
      cycle();
    end

    set_in(0,0,0,0,0,'0,0,0); cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
